// File: rtl/class_tree_walker.sv
// class_tree_walker: walks a binary decision tree held in a register-array
// node table, one node per cycle, to classify a binary feature vector.
//
// Node word layout (MSB..LSB): {leaf, feat, t_child, f_child, class}.
// A non-leaf node tests feature bit [feat]. A set bit moves to t_child and a
// clear bit moves to f_child. A feat index >= N_FEAT reads as 0. A walk that
// visits MAX_STEPS nodes without reaching a leaf ends with o=0, o_err=1.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i, in_valid         feature vector and its valid; accepted while in_ready
//   in_ready            high in IDLE
//   o, o_err, out_valid result class, step-limit flag, result valid (DONE)
//   out_ready           downstream accepts the result
//   nw_en/addr/data     node-table write port; acts only when not busy
//   busy                high outside IDLE
//   stat_cnt            completed-result count (saturating)
//
// Optional feature: define TREE_STATS_EN to build the stat_cnt counter.
// Without it, stat_cnt is tied to 0.
module class_tree_walker #(
  parameter  int N_FEAT    = 51,
  parameter  int N_NODES   = 64,
  parameter  int CLASS_W   = 2,
  parameter  int MAX_STEPS = 16,
  localparam int ADDR_W    = $clog2(N_NODES),
  localparam int FIDX_W    = $clog2(N_FEAT),
  localparam int NODE_W    = 1 + FIDX_W + 2*ADDR_W + CLASS_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_FEAT-1:0]  i,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [CLASS_W-1:0] o,
  output logic               o_err,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               nw_en,
  input  logic [ADDR_W-1:0]  nw_addr,
  input  logic [NODE_W-1:0]  nw_data,
  output logic               busy,
  output logic [15:0]        stat_cnt
);

  localparam int STEP_W = $clog2(MAX_STEPS + 1);
  localparam int FPAD   = 1 << FIDX_W;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEPS - 1);
  localparam logic [FIDX_W:0]   NF        = FIDX_W'(N_FEAT - 1) + 1'b1;
  localparam logic [NODE_W-1:0] LEAF0     = {1'b1, {(NODE_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

  state_t              state, state_nx;
  logic [N_FEAT-1:0]   feat_q;
  logic [ADDR_W-1:0]   cur, cur_nx;
  logic [STEP_W-1:0]   steps, steps_nx;
  logic                hit, hit_nx;
  logic [CLASS_W-1:0]  o_nx;
  logic                o_err_nx;
  logic [NODE_W-1:0]   node [N_NODES];

  // Combinational decode of the current node.
  logic [NODE_W-1:0]   nd;
  logic                nd_leaf;
  logic [FIDX_W-1:0]   nd_feat;
  logic [ADDR_W-1:0]   nd_t, nd_f;
  logic [CLASS_W-1:0]  nd_cls;
  logic [FPAD-1:0]     feat_pad;
  logic                fbit;

  assign nd       = node[cur];
  assign nd_leaf  = nd[NODE_W-1];
  assign nd_feat  = nd[NODE_W-2 -: FIDX_W];
  assign nd_t     = nd[2*ADDR_W+CLASS_W-1 -: ADDR_W];
  assign nd_f     = nd[ADDR_W+CLASS_W-1 -: ADDR_W];
  assign nd_cls   = nd[CLASS_W-1:0];
  // Pad to the full index range so any feat value selects in range; the
  // compare forces out-of-range features to 0.
  assign feat_pad = FPAD'(feat_q);
  assign fbit     = feat_pad[nd_feat] & ({1'b0, nd_feat} < NF);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // The walk registers its result and raises hit. DONE follows one cycle
  // later, so a leaf at depth d gives out_valid d+2 edges after acceptance.
  always_comb begin
    state_nx = state;
    cur_nx   = cur;
    steps_nx = steps;
    hit_nx   = hit;
    o_nx     = o;
    o_err_nx = o_err;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nx = WALK;
          cur_nx   = '0;
          steps_nx = '0;
          hit_nx   = 1'b0;
        end
      end
      WALK: begin
        if (hit) begin
          state_nx = DONE;
        end else if (nd_leaf) begin
          o_nx     = nd_cls;
          o_err_nx = 1'b0;
          hit_nx   = 1'b1;
        end else if (steps == LAST_STEP) begin
          // MAX_STEPS nodes visited with no leaf: abort.
          o_nx     = '0;
          o_err_nx = 1'b1;
          hit_nx   = 1'b1;
          steps_nx = steps + 1'b1;
        end else begin
          cur_nx   = fbit ? nd_t : nd_f;
          steps_nx = steps + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cur    <= '0;
      steps  <= '0;
      hit    <= 1'b0;
      o      <= '0;
      o_err  <= 1'b0;
      feat_q <= '0;
    end else begin
      state <= state_nx;
      cur   <= cur_nx;
      steps <= steps_nx;
      hit   <= hit_nx;
      o     <= o_nx;
      o_err <= o_err_nx;
      if (state == IDLE && in_valid) feat_q <= i;
    end
  end

  // Node table. Writes are accepted only in IDLE. A write on the accepting
  // edge lands before the first evaluation, so the walk sees it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_NODES; k++) node[k] <= LEAF0;
    end else if (nw_en && state == IDLE) begin
      node[nw_addr] <= nw_data;
    end
  end

`ifdef TREE_STATS_EN
  logic [15:0] cnt;
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (out_valid && out_ready && cnt != 16'hFFFF)
      cnt <= cnt + 1'b1;
  end
  assign stat_cnt = cnt;
`else
  assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_class_tree_walker.sv
module tb_class_tree_walker;
  localparam int N_FEAT    = 51;
  localparam int N_NODES   = 64;
  localparam int CLASS_W   = 2;
  localparam int MAX_STEPS = 16;
  localparam int ADDR_W    = $clog2(N_NODES);
  localparam int FIDX_W    = $clog2(N_FEAT);
  localparam int NODE_W    = 1 + FIDX_W + 2*ADDR_W + CLASS_W;

  logic               clk = 0;
  logic               rst = 1;
  logic [N_FEAT-1:0]  i = '0;
  logic               in_valid = 0;
  logic               in_ready;
  logic [CLASS_W-1:0] o;
  logic               o_err;
  logic               out_valid;
  logic               out_ready = 0;
  logic               nw_en = 0;
  logic [ADDR_W-1:0]  nw_addr = '0;
  logic [NODE_W-1:0]  nw_data = '0;
  logic               busy;
  logic [15:0]        stat_cnt;

  class_tree_walker #(.N_FEAT(N_FEAT), .N_NODES(N_NODES), .CLASS_W(CLASS_W),
                      .MAX_STEPS(MAX_STEPS)) dut (
    .clk(clk), .rst(rst), .i(i), .in_valid(in_valid), .in_ready(in_ready),
    .o(o), .o_err(o_err), .out_valid(out_valid), .out_ready(out_ready),
    .nw_en(nw_en), .nw_addr(nw_addr), .nw_data(nw_data), .busy(busy),
    .stat_cnt(stat_cnt));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int completions = 0;

  // Reference tree, kept as separate field arrays.
  int m_leaf [N_NODES];
  int m_feat [N_NODES];
  int m_t    [N_NODES];
  int m_f    [N_NODES];
  int m_cls  [N_NODES];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NODE_W-1:0] mk(input logic lf, input int ft, input int tc,
                                           input int fc, input int cl);
    return {lf, FIDX_W'(ft), ADDR_W'(tc), ADDR_W'(fc), CLASS_W'(cl)};
  endfunction

  function automatic void set_model(input int a, input logic [NODE_W-1:0] w);
    m_leaf[a] = int'(w[NODE_W-1]);
    m_feat[a] = int'(w[NODE_W-2 -: FIDX_W]);
    m_t[a]    = int'(w[2*ADDR_W+CLASS_W-1 -: ADDR_W]);
    m_f[a]    = int'(w[ADDR_W+CLASS_W-1 -: ADDR_W]);
    m_cls[a]  = int'(w[CLASS_W-1:0]);
  endfunction

  function automatic void reset_model();
    for (int a = 0; a < N_NODES; a++) set_model(a, mk(1'b1, 0, 0, 0, 0));
  endfunction

  // Walk the tree: n nodes visited gives out_valid at n+1 edges after accept.
  function automatic void ref_walk(input logic [N_FEAT-1:0] v, output int cls,
                                   output int err, output int lat);
    int c = 0;
    for (int n = 1; n <= MAX_STEPS; n++) begin
      if (m_leaf[c] != 0) begin
        cls = m_cls[c]; err = 0; lat = n + 1;
        return;
      end
      if (m_feat[c] < N_FEAT && v[m_feat[c]]) c = m_t[c];
      else c = m_f[c];
    end
    cls = 0; err = 1; lat = MAX_STEPS + 1;
  endfunction

  function automatic int exp_stat();
`ifdef TREE_STATS_EN
    return completions;
`else
    return 0;
`endif
  endfunction

  task automatic wr_node(input int a, input logic [NODE_W-1:0] w);
    nw_en = 1; nw_addr = ADDR_W'(a); nw_data = w;
    @(posedge clk); @(negedge clk);
    nw_en = 0;
    set_model(a, w);
  endtask

  // Offer v (optionally with a same-edge table write), wait for the result,
  // check it, optionally hold DONE for `hold` cycles, then release it.
  task automatic classify(input logic [N_FEAT-1:0] v, input bit wr, input int wa,
                          input logic [NODE_W-1:0] wd, input int hold, input string tag);
    int ecls, eerr, elat, n;
    chk({tag, ".rdy"}, in_ready, 1);
    i = v; in_valid = 1;
    nw_en = wr; nw_addr = ADDR_W'(wa); nw_data = wd;
    if (wr) set_model(wa, wd);
    ref_walk(v, ecls, eerr, elat);
    @(posedge clk); @(negedge clk);
    in_valid = 0; nw_en = 0;
    chk({tag, ".busy"}, busy, 1);
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); n++; @(negedge clk);
    end
    chk({tag, ".lat"}, n, elat);
    chk({tag, ".o"}, o, ecls);
    chk({tag, ".err"}, o_err, eerr);
    for (int k = 0; k < hold; k++) begin
      if (k == 0) begin
        // Dropped: the walker is busy. Model is deliberately not updated.
        nw_en = 1; nw_addr = '0; nw_data = mk(1'b1, 0, 0, 0, 2);
      end
      @(posedge clk); @(negedge clk);
      nw_en = 0;
      chk({tag, ".hold_o"}, o, ecls);
      chk({tag, ".hold_rdy"}, in_ready, 0);
      chk({tag, ".hold_vld"}, out_valid, 1);
    end
    out_ready = 1;
    @(posedge clk); @(negedge clk);
    out_ready = 0;
    completions++;
    chk({tag, ".rel_vld"}, out_valid, 0);
    chk({tag, ".rel_rdy"}, in_ready, 1);
  endtask

  function automatic logic [N_FEAT-1:0] rvec();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[N_FEAT-1:0];
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N_FEAT-1:0] v;
    reset_model();
    @(negedge clk); @(negedge clk);
    rst = 0;
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.busy", busy, 0);
    chk("rst.o", o, 0);
    chk("rst.o_err", o_err, 0);
    chk("rst.stat", stat_cnt, 0);

    // Empty table: root is a class-0 leaf.
    classify('0, 0, 0, '0, 0, "zero");

    // Small two-level tree on feature 50.
    wr_node(0, mk(1'b0, 50, 1, 2, 0));
    wr_node(1, mk(1'b1, 0, 0, 0, 3));
    wr_node(2, mk(1'b1, 0, 0, 0, 1));
    v = '0; v[50] = 1'b1;
    classify(v, 0, 0, '0, 0, "f50_set");
    v = '1; v[50] = 1'b0;
    classify(v, 0, 0, '0, 0, "f50_clr");
    chk("stat3", stat_cnt, exp_stat());

    // Hold DONE; a write during the hold must be dropped.
    v = '0; v[50] = 1'b1;
    classify(v, 0, 0, '0, 5, "hold");
    classify(v, 0, 0, '0, 0, "after_hold");

    // Out-of-range feature index reads as 0.
    wr_node(0, mk(1'b0, 60, 1, 2, 0));
    classify('1, 0, 0, '0, 0, "feat_oor");

    // Self-loop: step-limit abort.
    wr_node(0, mk(1'b0, 3, 0, 0, 0));
    classify('1, 0, 0, '0, 0, "selfloop");

    // Write on the accepting edge is seen by the walk.
    classify(rvec(), 1, 0, mk(1'b1, 0, 0, 0, 2), 0, "simul_wr");

    // Random tables and vectors, including loops and out-of-range features.
    for (int t = 0; t < 2; t++) begin
      for (int a = 0; a < N_NODES; a++)
        wr_node(a, mk(1'($urandom_range(0, 2) == 0), $urandom_range(0, 63),
                      $urandom_range(0, N_NODES-1), $urandom_range(0, N_NODES-1),
                      $urandom_range(0, 3)));
      for (int k = 0; k < 15; k++) classify(rvec(), 0, 0, '0, 0, "rand");
    end
    chk("stat_rand", stat_cnt, exp_stat());

    // Reset mid-walk: no result, counter and table cleared.
    wr_node(0, mk(1'b0, 3, 0, 0, 0));
    i = '0; in_valid = 1;
    @(posedge clk); @(negedge clk);
    in_valid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(posedge clk); @(negedge clk);
    rst = 0;
    reset_model();
    completions = 0;
    chk("midrst.out_valid", out_valid, 0);
    chk("midrst.in_ready", in_ready, 1);
    chk("midrst.busy", busy, 0);
    chk("midrst.stat", stat_cnt, 0);
    classify(rvec(), 0, 0, '0, 0, "post_rst");
    chk("post_rst.stat", stat_cnt, exp_stat());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/class_tree_walker.md
CLASS_TREE_WALKER -- requirements
Module: class_tree_walker

Interface
REQ-001 Parameter N_FEAT, default 51: width of the binary feature vector.
REQ-002 Parameter N_NODES, default 64: node-table entries; ADDR_W = clog2(N_NODES).
REQ-003 Parameter CLASS_W, default 2: class-label width.
REQ-004 Parameter MAX_STEPS, default 16: maximum nodes visited per classification.
REQ-005 Derived FIDX_W = clog2(N_FEAT); NODE_W = 1+FIDX_W+2*ADDR_W+CLASS_W (21 at defaults).
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 i  input  N_FEAT  feature vector, sampled on input handshake.
REQ-009 in_valid  input  1  feature vector offered.
REQ-010 in_ready  output  1  walker can accept a vector.
REQ-011 o  output  CLASS_W  class result, stable while out_valid high.
REQ-012 o_err  output  1  result produced by step-limit abort.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  downstream accepts result.
REQ-015 nw_en  input  1  node-table write strobe.
REQ-016 nw_addr  input  ADDR_W  node-table write address.
REQ-017 nw_data  input  NODE_W  node word {leaf, feat, t_child, f_child, class}, MSB to LSB.
REQ-018 busy  output  1  high in any state other than IDLE.
REQ-019 stat_cnt  output  16  completed-classification count (see Configuration).

Function
REQ-020 FSM states IDLE, WALK, DONE; in_ready = (state==IDLE), out_valid = (state==DONE).
REQ-021 IDLE: in_valid high at a clock edge captures i into a feature register, sets cur=0 and steps=0, and enters WALK.
REQ-022 WALK: each cycle evaluates node[cur]; a leaf registers o=class and o_err=0, then enters DONE.
REQ-023 WALK, non-leaf: cur becomes t_child if feature register bit [feat] = 1, otherwise f_child; steps increments.
REQ-024 A feat value >= N_FEAT reads as feature bit 0 (takes f_child).
REQ-025 If steps reaches MAX_STEPS with no leaf visited, o=0 and o_err=1 are registered and the FSM enters DONE.
REQ-026 Latency: a leaf at depth d (root = depth 0) asserts out_valid d+2 edges after the accepting edge.
REQ-027 DONE: o and o_err hold until out_valid && out_ready at an edge; the FSM then returns to IDLE, and the next vector is accepted no earlier than the following edge.
REQ-028 Node writes take effect only in IDLE (nw_en && !busy) and update node[nw_addr] at the edge; writes while busy are dropped.
REQ-029 A simultaneous in_valid and nw_en in IDLE performs both; the walk sees the newly written entry.
REQ-030 Node reads are combinational from the register array; no read latency.

Reset
REQ-031 rst forces IDLE, o=0, o_err=0, out_valid=0, in_ready=1 (from the first post-reset cycle), busy=0, cur=0, steps=0, and stat_cnt=0.
REQ-032 rst sets every node entry to leaf=1, class=0, all other fields 0.
REQ-033 rst asserted mid-walk or in DONE aborts without producing a result; a pending result is discarded.

Configuration
REQ-034 With macro TREE_STATS_EN defined, stat_cnt increments on each out_valid && out_ready and saturates at 0xFFFF.
REQ-035 Without TREE_STATS_EN, no counter is built and stat_cnt is tied to 0; the port list is unchanged.

Verification
REQ-036 Post-reset, vector 0x0 accepted -> out_valid 2 edges later, o=0, o_err=0.
REQ-037 Load node0 = {0, feat 50, t 1, f 2, -}, node1 = leaf class 3, node2 = leaf class 1; i[50]=1 -> o=3 at latency 3; i[50]=0 -> o=1.
REQ-038 Node0 non-leaf with both children 0 (self-loop) -> o=0, o_err=1 after MAX_STEPS steps.
REQ-039 Hold out_ready=0 for 5 cycles in DONE -> o stable, in_ready=0, and an nw_en issued meanwhile leaves the table unchanged.
REQ-040 With TREE_STATS_EN, 3 completed results -> stat_cnt=3; rst asserted mid-walk -> stat_cnt=0, out_valid=0, node table at leaf/class 0.
